// File: rtl/diff_demo_pkg.sv
// Shared types and helpers for the precision-scalable MAC.
// Contents: psum width default, lane mode enum, lane count/width helpers.
package diff_demo_pkg;

    localparam int unsigned PSUM_WIDTH = 48;
    localparam int unsigned ACC_W_DEF  = PSUM_WIDTH;

    typedef enum logic [1:0] {
        MODE_FULL    = 2'b00,
        MODE_HALF    = 2'b01,
        MODE_QUARTER = 2'b10,
        MODE_ILLEGAL = 2'b11
    } mac_mode_e;

    // Number of independent accumulator lanes for a mode.
    function automatic int unsigned lane_count(input mac_mode_e m);
        case (m)
            MODE_HALF:    return 2;
            MODE_QUARTER: return 4;
            default:      return 1;
        endcase
    endfunction

    // Width of one lane's field within the packed result.
    function automatic int unsigned lane_width(input int unsigned acc_w, input mac_mode_e m);
        return acc_w / lane_count(m);
    endfunction

endpackage

// File: rtl/prec_mac_lane_sat.sv
// Saturating accumulator lane with sticky saturation flag.
// Ports: clk, rst_n; en advances the lane; first restarts the sum; last
// clears state after the current sum is presented; add is the lane
// contribution; max is the runtime saturation limit; sum_c/sat_c are the
// combinational updated sum and flag for the current beat.
module prec_mac_lane_sat #(
    parameter int unsigned W = 48
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         first,
    input  logic         last,
    input  logic [W-1:0] add,
    input  logic [W-1:0] max,
    output logic [W-1:0] sum_c,
    output logic         sat_c
);

    logic [W-1:0] acc_q;
    logic         sat_q;
    logic [W:0]   raw;

    // One extra bit catches overflow past the lane limit.
    always_comb begin
        raw   = (first ? '0 : {1'b0, acc_q}) + {1'b0, add};
        sum_c = raw[W-1:0];
        sat_c = first ? 1'b0 : sat_q;
        if (raw > {1'b0, max}) begin
            sum_c = max;
            sat_c = 1'b1;
        end
    end

    // A last beat hands its sum downstream and leaves the lane empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else if (en) begin
            if (last) begin
                acc_q <= '0;
                sat_q <= 1'b0;
            end else begin
                acc_q <= sum_c;
                sat_q <= sat_c;
            end
        end
    end

endmodule

// File: rtl/prec_mac_pipe.sv
// Precision-scalable pipelined MAC: operand a split into 1/2/4 lanes, each
// multiplied by shared b and accumulated with saturation over a packet.
// Ports: clk, rst_n; in_valid/in_ready/in_mode/in_first/in_last/in_a/in_b
// input beat; out_valid/out_ready/out_ans/out_sat result; mode_err sticky
// illegal-mode flag.
module prec_mac_pipe
    import diff_demo_pkg::*;
#(
    parameter int unsigned A_W   = 8,
    parameter int unsigned B_W   = 8,
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic             in_first,
    input  logic             in_last,
    input  logic [A_W-1:0]   in_a,
    input  logic [B_W-1:0]   in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_ans,
    output logic [3:0]       out_sat,
    output logic             mode_err
);

    localparam int unsigned G_W = A_W / 4;
    localparam int unsigned P_W = B_W + G_W;
    localparam int unsigned H_W = ACC_W / 2;
    localparam int unsigned Q_W = ACC_W / 4;

    logic adv;
    logic take;
    assign adv      = ~(out_valid & ~out_ready);
    assign in_ready = adv;
    assign take     = in_valid & adv;

    // Illegal mode runs as full precision; later beats reuse the latched mode.
    mac_mode_e mode_q, in_mode_dec, beat_mode;
    always_comb begin
        in_mode_dec = mac_mode_e'(in_mode);
        if (in_mode_dec == MODE_ILLEGAL) in_mode_dec = MODE_FULL;
        beat_mode = in_first ? in_mode_dec : mode_q;
    end

    // Stage 1: granule products and beat flags.
    logic           s1_valid, s1_first, s1_last;
    mac_mode_e      s1_mode;
    logic [P_W-1:0] s1_p [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_mode  <= MODE_FULL;
            mode_q   <= MODE_FULL;
            mode_err <= 1'b0;
            for (int g = 0; g < 4; g++) s1_p[g] <= '0;
        end else if (adv) begin
            s1_valid <= take;
            if (take) begin
                s1_first <= in_first;
                s1_last  <= in_last;
                s1_mode  <= beat_mode;
                for (int g = 0; g < 4; g++)
                    s1_p[g] <= P_W'(in_a[g*G_W +: G_W]) * P_W'(in_b);
                if (in_first) mode_q <= in_mode_dec;
                if (in_first && (in_mode == 2'b11)) mode_err <= 1'b1;
            end
        end
    end

    // Stage 2: combine granule products into lane contributions.
    logic [ACC_W-1:0] comb_add [4];
    always_comb begin
        for (int k = 0; k < 4; k++) comb_add[k] = '0;
        case (s1_mode)
            MODE_HALF: begin
                comb_add[0] = ACC_W'(s1_p[0]) + (ACC_W'(s1_p[1]) << G_W);
                comb_add[1] = ACC_W'(s1_p[2]) + (ACC_W'(s1_p[3]) << G_W);
            end
            MODE_QUARTER: begin
                for (int k = 0; k < 4; k++) comb_add[k] = ACC_W'(s1_p[k]);
            end
            default: begin
                for (int g = 0; g < 4; g++)
                    comb_add[0] = comb_add[0] + (ACC_W'(s1_p[g]) << (g * G_W));
            end
        endcase
    end

    logic             s2_valid, s2_first, s2_last;
    mac_mode_e        s2_mode;
    logic [ACC_W-1:0] s2_add [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            s2_mode  <= MODE_FULL;
            for (int k = 0; k < 4; k++) s2_add[k] <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_first <= s1_first;
                s2_last  <= s1_last;
                s2_mode  <= s1_mode;
                for (int k = 0; k < 4; k++) s2_add[k] <= comb_add[k];
            end
        end
    end

    // Accumulate: limit is all-ones over the active lane field width.
    int unsigned      lane_w;
    logic [ACC_W-1:0] lane_max;
    always_comb begin
        lane_w   = lane_width(ACC_W, s2_mode);
        lane_max = '1;
        lane_max = lane_max >> (ACC_W - lane_w);
    end

    logic [ACC_W-1:0] lane_sum [4];
    logic [3:0]       lane_sat;

    for (genvar k = 0; k < 4; k++) begin : g_lane
        prec_mac_lane_sat #(.W(ACC_W)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (s2_valid & adv),
            .first (s2_first),
            .last  (s2_last),
            .add   (s2_add[k]),
            .max   (lane_max),
            .sum_c (lane_sum[k]),
            .sat_c (lane_sat[k])
        );
    end

    // Pack lane sums; each sum is already bounded by its field width.
    logic [ACC_W-1:0] pack_ans;
    logic [3:0]       pack_sat;
    always_comb begin
        case (s2_mode)
            MODE_HALF: begin
                pack_ans = lane_sum[0] | (lane_sum[1] << H_W);
                pack_sat = {2'b00, lane_sat[1:0]};
            end
            MODE_QUARTER: begin
                pack_ans = lane_sum[0] | (lane_sum[1] << Q_W)
                         | (lane_sum[2] << (2 * Q_W)) | (lane_sum[3] << (3 * Q_W));
                pack_sat = lane_sat;
            end
            default: begin
                pack_ans = lane_sum[0];
                pack_sat = {3'b000, lane_sat[0]};
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_ans   <= '0;
            out_sat   <= '0;
        end else if (adv) begin
            out_valid <= s2_valid & s2_last;
            if (s2_valid && s2_last) begin
                out_ans <= pack_ans;
                out_sat <= pack_sat;
            end
        end
    end

endmodule
